mc_ctrl_unit: RTL

Multicycle microcontrol sequencer that drives the ALU's 3-bit `control` code, operand selects and datapath strobes for a MIPS-subset datapath. It is the issuing end of the ALU control interface: it decodes opcode/funct, steps a Moore state machine through fetch/decode/execute/memory/writeback, and consumes the ALU zero flag for branches. It sits in `Micro_ctrl` between the instruction register and the datapath (ALU, register file, memory port).

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_unit_alu_ctrl_dec.sv | 50 +++++
 rtl/mc_ctrl_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle microcontrol sequencer.
//   - state_e     : FSM state numbering (also exported on the debug port)
//   - OP_* / FN_* : MIPS opcode and funct values understood by the sequencer
//   - ALU_*       : 3-bit ALU control codes
//   - SRCB_* / PCSRC_* : operand-B and PC-source mux encodings
//   - alu_cls_e   : which ALU decode rule applies in the current state
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // NONE means the ALU is idle in this state and its control code reads 000.
  typedef enum logic [2:0] {
    AC_NONE, AC_ADD, AC_SUB, AC_RTYPE, AC_ITYPE
  } alu_cls_e;

endpackage

// File: rtl/mc_ctrl_unit_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU control decode.
//   i_cls        : decode rule selected by the FSM state
//   i_opcode     : IR[31:26] (I-type op select)
//   i_funct      : IR[5:0]   (R-type op select)
//   o_alu_ctl    : 3-bit ALU control
//   o_ext_zero   : zero-extend the immediate (andi/ori)
//   o_funct_ill  : R-type funct not recognised
module alu_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  alu_cls_e    i_cls,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_ctl,
  output logic        o_ext_zero,
  output logic        o_funct_ill
);

  always_comb begin
    o_alu_ctl   = ALU_AND;
    o_ext_zero  = 1'b0;
    o_funct_ill = 1'b0;
    case (i_cls)
      AC_ADD: o_alu_ctl = ALU_ADD;
      AC_SUB: o_alu_ctl = ALU_SUB;
      AC_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_ctl = ALU_ADD;
          FN_SUB:  o_alu_ctl = ALU_SUB;
          FN_AND:  o_alu_ctl = ALU_AND;
          FN_OR:   o_alu_ctl = ALU_OR;
          FN_NOR:  o_alu_ctl = ALU_NOR;
          FN_SLT:  o_alu_ctl = ALU_SLT;
          // unknown funct still executes as an add so the datapath stays defined
          default: begin o_alu_ctl = ALU_ADD; o_funct_ill = 1'b1; end
        endcase
      end
      AC_ITYPE: begin
        case (i_opcode)
          OP_ANDI: begin o_alu_ctl = ALU_AND; o_ext_zero = 1'b1; end
          OP_ORI:  begin o_alu_ctl = ALU_OR;  o_ext_zero = 1'b1; end
          OP_SLTI: o_alu_ctl = ALU_SLT;
          default: o_alu_ctl = ALU_ADD;
        endcase
      end
      default: o_alu_ctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle Moore microcontrol sequencer for a MIPS-subset
// datapath. Steps FETCH/DECODE/execute/memory/writeback and drives ALU
// control, operand selects and datapath strobes.
//   clk, rst_n (sync, active low), opcode, funct, alu_zf, mem_rdy : inputs
//   alu_control, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
//   mem_write, ir_write, reg_write, reg_dst, mem_to_reg, ext_zero : datapath
//   illegal, mem_timeout (sticky), instr_cnt, state (debug)       : status
// Build option: MC_CTRL_BNE_EN enables bne (opcode 000101) via BRANCH.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zf,
  input  logic        mem_rdy,
  output logic [2:0]  alu_control,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        ext_zero,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [31:0] instr_cnt,
  output logic [3:0]  state
);

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

  state_e      r_state, w_next;
  logic [31:0] r_instr_cnt;
  logic [3:0]  r_wait;
  logic        r_illegal, r_timeout;

  alu_cls_e    w_cls;
  logic [2:0]  w_alu_ctl;
  logic        w_ext_zero, w_funct_ill;
  logic        w_retire, w_dec_ill, w_wait_st, w_wait_entry;

  alu_ctrl_dec u_dec (
    .i_cls       (w_cls),
    .i_opcode    (opcode),
    .i_funct     (funct),
    .o_alu_ctl   (w_alu_ctl),
    .o_ext_zero  (w_ext_zero),
    .o_funct_ill (w_funct_ill)
  );

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         w_next = S_R_EXE;
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_BEQ:                           w_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:                           w_next = S_BRANCH;
`endif
          OP_J:                             w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_I_EXE;
          default:                          w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_rdy ? S_FETCH : S_MEM_WR;
      S_R_EXE:    w_next = S_R_WB;
      S_I_EXE:    w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // DECODE is the only state that can fall back to FETCH without retiring.
  assign w_dec_ill = (r_state == S_DECODE) && (w_next == S_FETCH);
  assign w_retire  = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_DECODE);

  assign w_wait_st    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_wait_entry = (w_next != r_state) &&
                        ((w_next == S_FETCH) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_instr_cnt <= '0;
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
      if (w_dec_ill || ((r_state == S_R_EXE) && w_funct_ill)) r_illegal <= 1'b1;
      if (w_wait_entry) begin
        r_wait <= '0;
      end else if (w_wait_st && !mem_rdy && (r_wait != WAIT_MAX)) begin
        r_wait <= r_wait + 4'd1;
        if (r_wait + 4'd1 == WAIT_MAX) r_timeout <= 1'b1;
      end
    end
  end

  // Moore decode; mem_rdy/alu_zf only qualify pc_en and ir_write.
  always_comb begin
    w_cls      = AC_NONE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    pc_source  = PCSRC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        w_cls     = AC_ADD;
        ir_write  = mem_rdy;
        pc_en     = mem_rdy;
      end
      S_DECODE:   begin alu_src_b = SRCB_IMM_SH2; w_cls = AC_ADD; end
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; w_cls = AC_ADD; end
      S_MEM_RD:   begin iord = 1'b1; mem_read = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WR:   begin iord = 1'b1; mem_write = 1'b1; end
      S_R_EXE:    begin alu_src_a = 1'b1; w_cls = AC_RTYPE; end
      S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        w_cls     = AC_SUB;
`ifdef MC_CTRL_BNE_EN
        pc_en     = (opcode == OP_BNE) ? ~alu_zf : alu_zf;
`else
        pc_en     = alu_zf;
`endif
      end
      S_JUMP:     begin pc_source = PCSRC_JUMP; pc_en = 1'b1; end
      S_I_EXE:    begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; w_cls = AC_ITYPE; end
      S_I_WB:     reg_write = 1'b1;
      default:    w_cls = AC_NONE;
    endcase
    if (!rst_n) begin
      alu_src_a  = 1'b0;
      alu_src_b  = '0;
      pc_source  = '0;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign alu_control = rst_n ? w_alu_ctl  : 3'b000;
  assign ext_zero    = rst_n ? w_ext_zero : 1'b0;

  assign illegal     = r_illegal;
  assign mem_timeout = r_timeout;
  assign instr_cnt   = r_instr_cnt;
  assign state       = r_state;

endmodule
